// File: rtl/msg_fetch_unit.sv
// -----------------------------------------------------------------------------
// msg_fetch_unit
//
// Fetches one 32-bit word from a request/grant bus on behalf of a processing
// element. It also keeps an eight-entry message buffer, indexed by address
// bits [4:2], that is updated on every successful read.
//
// Optional feature: define MSG_TIMEOUT_EN to add a read-wait watchdog. When it
// fires, the fetch completes with ERR_WORD and the sticky err flag is set.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-high reset
//   mem_read     : level-held read request from the processing element
//   mem_address  : byte address of the read (latched when the read is accepted)
//   mem_ack      : one-cycle read-complete pulse
//   mem_Message  : read data, valid while mem_ack=1, held between reads
//   messages     : eight-entry message buffer, entry = address[4:2]
//   bus_req      : bus request (high in REQ)
//   bus_addr     : bus address (latched read address)
//   bus_gnt      : bus grant
//   bus_rvalid   : bus read data valid
//   bus_rdata    : bus read data
//   err          : sticky watchdog timeout flag (tied 0 without MSG_TIMEOUT_EN)
//   fsm_state    : debug view of the FSM state (IDLE=0 REQ=1 WAIT=2 ACK=3 DONE=4)
//
// Handshake: mem_read is a level request. It is accepted only in IDLE, and
// exactly one mem_ack pulse answers it. Another read can start only after
// mem_read has been seen low. On the bus side, a beat completes on a rising
// edge where the sampled signal is high: bus_gnt in REQ, and bus_rvalid in
// WAIT (or in REQ together with bus_gnt). The unit ignores bus_rvalid at any
// other time.
// -----------------------------------------------------------------------------
module msg_fetch_unit #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_WORD       = 32'hDEADBEEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic [31:0]      mem_address,
  output logic             mem_ack,
  output logic [31:0]      mem_Message,
  output logic [7:0][31:0] messages,
  output logic             bus_req,
  output logic [31:0]      bus_addr,
  input  logic             bus_gnt,
  input  logic             bus_rvalid,
  input  logic [31:0]      bus_rdata,
  output logic             err,
  output logic [2:0]       fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_ACK  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state;
  state_t next_state;
  logic   capture;   // bus_rdata is taken on this edge

`ifdef MSG_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;
  logic            timeout;
  logic            err_q;

  // Firing on count TIMEOUT_CYCLES-1 gives exactly TIMEOUT_CYCLES cycles in WAIT.
  assign wd_hit  = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  // Real data arriving on the last cycle beats the watchdog.
  assign timeout = (state == S_WAIT) && !bus_rvalid && wd_hit;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_read) next_state = S_REQ;
      end
      S_REQ: begin
        if (bus_gnt) begin
          // Grant and data in the same cycle: skip WAIT entirely.
          if (bus_rvalid) begin
            capture    = 1'b1;
            next_state = S_ACK;
          end else begin
            next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus_rvalid) begin
          capture    = 1'b1;
          next_state = S_ACK;
        end
`ifdef MSG_TIMEOUT_EN
        else if (timeout) begin
          next_state = S_ACK;
        end
`endif
      end
      S_ACK: begin
        next_state = S_DONE;
      end
      S_DONE: begin
        // A request still held high is the one just served; wait for it to drop.
        if (!mem_read) next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_req   = (state == S_REQ);
    mem_ack   = (state == S_ACK);
    fsm_state = state;
  end

  // ---------------------------------------------------------------------------
  // Datapath: latched address, read data and message buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_addr    <= '0;
      mem_Message <= '0;
      messages    <= '0;
    end else begin
      // Address is sampled only at accept; later changes are ignored.
      if ((state == S_IDLE) && mem_read) begin
        bus_addr <= mem_address;
      end
      if (capture) begin
        mem_Message                <= bus_rdata;
        messages[bus_addr[4:2]]    <= bus_rdata;
      end
`ifdef MSG_TIMEOUT_EN
      else if (timeout) begin
        // A timed-out read reports ERR_WORD but leaves the buffer untouched.
        mem_Message <= ERR_WORD;
      end
`endif
    end
  end

`ifdef MSG_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Watchdog: counts WAIT cycles, cleared whenever WAIT is left
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state == S_WAIT) && (next_state == S_WAIT)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  // Without the watchdog, TIMEOUT_CYCLES has no effect. Both arms tie err low.
  if (TIMEOUT_CYCLES > 0) begin : g_err_tie
    assign err = 1'b0;
  end else begin : g_err_tie_zero
    assign err = 1'b0;
  end
`endif

endmodule

// File: tb/tb_msg_fetch_unit.sv
module tb_msg_fetch_unit;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             reset;
  logic             mem_read;
  logic [31:0]      mem_address;
  logic             mem_ack;
  logic [31:0]      mem_Message;
  logic [7:0][31:0] messages;
  logic             bus_req;
  logic [31:0]      bus_addr;
  logic             bus_gnt;
  logic             bus_rvalid;
  logic [31:0]      bus_rdata;
  logic             err;
  logic [2:0]       fsm_state;

  always #5 clk = ~clk;

  msg_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_address (mem_address),
    .mem_ack     (mem_ack),
    .mem_Message (mem_Message),
    .messages    (messages),
    .bus_req     (bus_req),
    .bus_addr    (bus_addr),
    .bus_gnt     (bus_gnt),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata),
    .err         (err),
    .fsm_state   (fsm_state)
  );

  localparam logic [31:0] JUNK = 32'hBAD0BAD0;

  // ---------------------------------------------------------------------------
  // Vector record: one read transaction and its hand-computed results
  //   gw    : REQ cycles before bus_gnt is raised
  //   dw    : WAIT cycles before bus_rvalid is raised
  //   same  : bus_rvalid raised together with bus_gnt
  //   noise : stray bus_rvalid with junk data where it must be ignored
  //   hold  : cycles mem_read stays high after mem_ack
  //   lat   : expected cycles from mem_read rise to mem_ack
  //   idx   : expected messages[] entry written
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          gw;
    int          dw;
    bit          same;
    bit          noise;
    int          hold;
    int          lat;
    int          idx;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] exp_msgs [8];
  int          n_checks = 0;
  int          n_errors = 0;

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_msgs(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s messages[%0d]", tag, i), messages[i], exp_msgs[i]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: runs one read described by v; called just after a negedge
  // ---------------------------------------------------------------------------
  task automatic do_read(input vec_t v);
    int lat;
    int req_seen;
    int wait_seen;
    int extra_acks;
    int extra_reqs;
    bit granted;
    lat        = -1;
    req_seen   = 0;
    wait_seen  = 0;
    extra_acks = 0;
    extra_reqs = 0;
    granted    = 1'b0;
    mem_read    = 1'b1;
    mem_address = v.addr;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = JUNK;
      // After the accept, a new address must be ignored.
      if (k == 1) mem_address = ~v.addr;
      if (mem_ack) begin
        lat = k;
        break;
      end
      if (bus_req) begin
        if (req_seen == 0) check("bus_addr", bus_addr, v.addr);
        if (req_seen == v.gw) begin
          bus_gnt = 1'b1;
          granted = 1'b1;
          if (v.same) begin
            bus_rvalid = 1'b1;
            bus_rdata  = v.data;
          end
        end else if (v.noise) begin
          bus_rvalid = 1'b1;
        end
        req_seen++;
      end else if (granted) begin
        if (wait_seen == v.dw) begin
          bus_rvalid = 1'b1;
          bus_rdata  = v.data;
        end
        wait_seen++;
      end
    end
    check("latency", lat, v.lat);
    check("mem_Message", mem_Message, v.data);
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      bus_rvalid = v.noise;
      bus_rdata  = JUNK;
      if (mem_ack) extra_acks++;
      if (bus_req) extra_reqs++;
    end
    check("single mem_ack", extra_acks, 0);
    check("no second bus_req", extra_reqs, 0);
    check("state DONE while held", fsm_state, 3'd4);
    mem_read   = 1'b0;
    bus_rvalid = 1'b0;
    @(negedge clk);
    check("state IDLE after drop", fsm_state, 3'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Global time limit
  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int acks;
    int lat;
    int enter;

    //            addr        data          gw dw same noise hold lat idx
    vecs[0] = '{32'h0000_0008, 32'h1234_5678, 1, 1, 1'b0, 1'b0, 1, 5, 2};
    vecs[1] = '{32'h0000_001C, 32'hA5A5_A5A5, 0, 0, 1'b1, 1'b0, 1, 2, 7};
    vecs[2] = '{32'h0000_0000, 32'h1111_1111, 0, 0, 1'b0, 1'b0, 1, 3, 0};
    vecs[3] = '{32'h0000_0004, 32'h2222_2222, 2, 0, 1'b0, 1'b1, 1, 5, 1};
    vecs[4] = '{32'h0000_0020, 32'h3333_3333, 0, 3, 1'b0, 1'b0, 1, 6, 0};
    vecs[5] = '{32'h0000_003C, 32'h4444_4444, 1, 0, 1'b1, 1'b1, 2, 3, 7};
    vecs[6] = '{32'h0000_0010, 32'h0BAD_F00D, 0, 0, 1'b0, 1'b1, 10, 3, 4};

    for (int i = 0; i < 8; i++) exp_msgs[i] = '0;

    reset       = 1'b1;
    mem_read    = 1'b0;
    mem_address = '0;
    bus_gnt     = 1'b0;
    bus_rvalid  = 1'b0;
    bus_rdata   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("reset state", fsm_state, 3'd0);
    check("reset mem_ack", mem_ack, 1'b0);
    check("reset bus_req", bus_req, 1'b0);
    check("reset err", err, 1'b0);
    check("reset bus_addr", bus_addr, 32'h0);
    check("reset mem_Message", mem_Message, 32'h0);
    check_msgs("reset");

    // Table-driven reads
    for (int i = 0; i < 7; i++) begin
      do_read(vecs[i]);
      exp_msgs[vecs[i].idx] = vecs[i].data;
      check_msgs($sformatf("vec%0d", i));
    end

    // Reset while in WAIT aborts the read; a late bus_rvalid is ignored
    mem_read    = 1'b1;
    mem_address = 32'h0000_0014;
    @(negedge clk);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    check("abort reached WAIT", fsm_state, 3'd2);
    #1 reset = 1'b1;
    #1;
    check("async reset state", fsm_state, 3'd0);
    check("async reset bus_req", bus_req, 1'b0);
    check("async reset mem_Message", mem_Message, 32'h0);
    check("async reset bus_addr", bus_addr, 32'h0);
    for (int i = 0; i < 8; i++) exp_msgs[i] = '0;
    check_msgs("async reset");
    mem_read = 1'b0;
    @(negedge clk);
    reset      = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h7777_7777;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_ack) acks++;
    end
    bus_rvalid = 1'b0;
    check("no ack after abort", acks, 0);
    check("IDLE after abort", fsm_state, 3'd0);
    check_msgs("after abort");

    // Read accepted on the first edge after reset release
    reset       = 1'b1;
    mem_read    = 1'b1;
    mem_address = 32'h0000_000C;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("accept after reset state", fsm_state, 3'd1);
    check("accept after reset bus_req", bus_req, 1'b1);
    check("accept after reset bus_addr", bus_addr, 32'h0000_000C);
    bus_gnt    = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h0C0C_0C0C;
    @(negedge clk);
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    mem_read   = 1'b0;
    check("accept after reset mem_ack", mem_ack, 1'b1);
    exp_msgs[3] = 32'h0C0C_0C0C;
    repeat (2) @(negedge clk);
    check("accept after reset back to IDLE", fsm_state, 3'd0);
    check_msgs("after reset read");

`ifdef MSG_TIMEOUT_EN
    // Watchdog: grant, then no data at all
    check("err before timeout", err, 1'b0);
    mem_read    = 1'b1;
    mem_address = 32'h0000_0018;
    lat   = -1;
    enter = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus_gnt = 1'b0;
      if (mem_ack) begin
        lat = k - enter;
        break;
      end
      if (bus_req) begin
        bus_gnt = 1'b1;
        enter   = k + 1;
      end
    end
    check("watchdog latency", lat, 16);
    check("watchdog mem_Message", mem_Message, 32'hDEAD_BEEF);
    check("watchdog err", err, 1'b1);
    check_msgs("after timeout");
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    check("IDLE after timeout", fsm_state, 3'd0);
    do_read(vecs[2]);
    exp_msgs[0] = vecs[2].data;
    check("err sticky", err, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("err cleared by reset", err, 1'b0);
`else
    check("err tied low", err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
